ctrl_trace_encoder: RTL and testbench

CTRL_TRACE_ENCODER -- requirements
Module: ctrl_trace_encoder

---
 rtl/ctrl_trace_encoder.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_trace_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_trace_encoder.sv
// ctrl_trace_encoder: re-encodes each captured control bundle into the
// opcode that would have produced it. The encoder also flags bundles that
// the decoder would not have produced for that opcode. Records are queued in
// an 8-entry first-word-fall-through FIFO, tagged with a free-running capture
// sequence number.
module ctrl_trace_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cap_en,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        ReadMem,
  input  logic        ALUSrc,
  input  logic        RegWrite,
  input  logic        immSrc,
  input  logic [3:0]  ALUOp,
  input  logic [1:0]  branch_src,
  input  logic        clear,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [13:0] rd_data,
  output logic [3:0]  count,
  output logic [7:0]  ovf_cnt,
  output logic        ovf
);

  localparam int unsigned DEPTH = 8;

  logic [4:0]  opcode;
  logic        err;

  // Bundle the decoder would emit for the recovered opcode.
  logic        exp_branch;
  logic        exp_memtoreg;
  logic        exp_memwrite;
  logic        exp_readmem;
  logic        exp_alusrc;
  logic        exp_regwrite;
  logic        exp_immsrc;
  logic [3:0]  exp_aluop;
  logic [1:0]  exp_bsrc;

  logic [13:0] mem [DEPTH];
  logic [2:0]  wptr;
  logic [2:0]  rptr;
  logic [3:0]  occ;
  logic [7:0]  seq;
  logic [7:0]  drops;
  logic        ovf_q;

  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  // Inverse decode: bundle -> opcode. Branch immediates are not recoverable.
  always_comb begin
    opcode = '0;
    if (!Branch) begin
      opcode = {1'b1, ALUOp};
    end else begin
      unique case (branch_src)
        2'b10:   opcode = 5'b00000;
        2'b11:   opcode = 5'b00100;
        2'b00:   opcode = 5'b01000;
        default: opcode = 5'b01100;
      endcase
    end
  end

  // Forward decode of the recovered opcode, used to detect inconsistent bundles.
  always_comb begin
    exp_branch   = 1'b0;
    exp_memtoreg = 1'b0;
    exp_memwrite = 1'b0;
    exp_readmem  = 1'b0;
    exp_alusrc   = 1'b0;
    exp_regwrite = 1'b0;
    exp_immsrc   = 1'b0;
    exp_aluop    = 4'hF;
    exp_bsrc     = 2'b11;
    if (opcode[4]) begin
      exp_aluop    = opcode[3:0];
      exp_regwrite = !(opcode[3:0] inside {4'b0110, 4'b0111, 4'b1011});
      exp_alusrc   = opcode[3:0] inside {4'b0111, 4'b1001, 4'b1100, 4'b1101};
      exp_memtoreg = (opcode[3:0] == 4'b1010);
      exp_readmem  = (opcode[3:0] == 4'b1010);
      exp_memwrite = (opcode[3:0] == 4'b1011);
    end else begin
      exp_branch = 1'b1;
      exp_immsrc = 1'b1;
      unique case (opcode[3:2])
        2'b00:   exp_bsrc = 2'b10;
        2'b01:   exp_bsrc = 2'b11;
        2'b10:   exp_bsrc = 2'b00;
        default: exp_bsrc = 2'b01;
      endcase
    end
  end

  // Any field differing from the forward decode marks the record as suspect.
  always_comb begin
    err = (Branch     != exp_branch)   ||
          (MemtoReg   != exp_memtoreg) ||
          (MemWrite   != exp_memwrite) ||
          (ReadMem    != exp_readmem)  ||
          (ALUSrc     != exp_alusrc)   ||
          (RegWrite   != exp_regwrite) ||
          (immSrc     != exp_immsrc)   ||
          (ALUOp      != exp_aluop)    ||
          (branch_src != exp_bsrc);
  end

  // Handshake: a pop frees a slot in the same cycle, so a full FIFO still
  // accepts a capture when the consumer is draining.
  always_comb begin
    full = (occ == 4'(DEPTH));
    pop  = (occ != 4'd0) && rd_ready;
    push = cap_en && (!full || pop);
    drop = cap_en && full && !pop;
  end

  // Pointer, occupancy, sequence and overflow bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      occ   <= '0;
      seq   <= '0;
      drops <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      occ   <= '0;
      seq   <= '0;
      drops <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (cap_en) begin
        seq <= seq + 8'd1;
      end
      if (push) begin
        wptr <= wptr + 3'd1;
      end
      if (pop) begin
        rptr <= rptr + 3'd1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 4'd1;
        2'b01:   occ <= occ - 4'd1;
        default: occ <= occ;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (drops != 8'hFF) begin
          drops <= drops + 8'd1;
        end
      end
    end
  end

  // Record storage; contents need no reset because the read side is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wptr] <= {seq, err, opcode};
    end
  end

  // Head-of-queue presentation and status outputs.
  always_comb begin
    rd_valid = (occ != 4'd0);
    rd_data  = rd_valid ? mem[rptr] : '0;
    count    = occ;
    ovf_cnt  = drops;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Directed testbench for ctrl_trace_encoder with hand-computed expectations.
module tb_ctrl_trace_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cap_en;
  logic        Branch, MemtoReg, MemWrite, ReadMem, ALUSrc, RegWrite, immSrc;
  logic [3:0]  ALUOp;
  logic [1:0]  branch_src;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [13:0] rd_data;
  logic [3:0]  count;
  logic [7:0]  ovf_cnt;
  logic        ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  expseq;
  int unsigned pops;

  ctrl_trace_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cap_en     (cap_en),
    .Branch     (Branch),
    .MemtoReg   (MemtoReg),
    .MemWrite   (MemWrite),
    .ReadMem    (ReadMem),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .immSrc     (immSrc),
    .ALUOp      (ALUOp),
    .branch_src (branch_src),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .ovf_cnt    (ovf_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic br, input logic m2r, input logic mw, input logic rm,
                            input logic as, input logic rw, input logic imm,
                            input logic [3:0] op, input logic [1:0] bs);
    Branch = br; MemtoReg = m2r; MemWrite = mw; ReadMem = rm;
    ALUSrc = as; RegWrite = rw; immSrc = imm; ALUOp = op; branch_src = bs;
  endtask

  // Capture one bundle into an empty FIFO, check the head record, then pop it.
  task automatic single(input string tag, input logic [4:0] op, input logic e);
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'({expseq, e, op}));
    expseq++;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk({tag, "_empty"}, 32'(count), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expseq = 8'd0;
  endtask

  initial begin
    reset_n = 1'b0; cap_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    set_bundle(0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    expseq = 8'd0;
    #12;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // rd_ready on an empty FIFO must be ignored
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("empty_pop", 32'(count), 32'd0);

    // load: ALUOp 1010 with memory read controls
    set_bundle(0, 1, 0, 1, 0, 1, 0, 4'b1010, 2'b11);
    single("ld", 5'b11010, 1'b0);
    // branch encodings
    set_bundle(1, 0, 0, 0, 0, 0, 1, 4'hF, 2'b00);
    single("br00", 5'b01000, 1'b0);
    set_bundle(1, 0, 0, 0, 0, 1, 1, 4'hF, 2'b00);
    single("br00_rw", 5'b01000, 1'b1);
    set_bundle(1, 0, 0, 0, 0, 0, 1, 4'hF, 2'b10);
    single("br10", 5'b00000, 1'b0);
    set_bundle(1, 0, 0, 0, 0, 0, 1, 4'hF, 2'b11);
    single("br11", 5'b00100, 1'b0);
    set_bundle(1, 0, 0, 0, 0, 0, 1, 4'hF, 2'b01);
    single("br01", 5'b01100, 1'b0);
    set_bundle(1, 0, 0, 0, 0, 0, 1, 4'h0, 2'b01);
    single("br01_alu", 5'b01100, 1'b1);
    // non-branch encodings
    set_bundle(0, 0, 0, 0, 1, 0, 0, 4'b0111, 2'b11);
    single("op0111", 5'b10111, 1'b0);
    set_bundle(0, 0, 1, 0, 0, 0, 0, 4'b1011, 2'b11);
    single("st", 5'b11011, 1'b0);
    set_bundle(0, 0, 0, 0, 1, 1, 0, 4'b1001, 2'b11);
    single("op1001", 5'b11001, 1'b0);
    set_bundle(0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b11);
    single("op0000_norw", 5'b10000, 1'b1);
    set_bundle(0, 0, 0, 0, 0, 1, 1, 4'b0010, 2'b11);
    single("op0010_imm", 5'b10010, 1'b1);
    set_bundle(0, 0, 0, 0, 0, 1, 0, 4'b0010, 2'b10);
    single("op0010_bsrc", 5'b10010, 1'b1);

    // ten captures with no reader: 8 stored, 2 dropped
    do_clear();
    set_bundle(0, 1, 0, 1, 0, 1, 0, 4'b1010, 2'b11);
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    cap_en = 1'b0;
    expseq = 8'd10;
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ovf", 32'(ovf), 32'd1);
    chk("fill_ovfcnt", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 32'(rd_data[13:6]), 32'(i));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // full FIFO with simultaneous push and pop
    cap_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("full2_count", 32'(count), 32'd8);
    rd_ready = 1'b1;
    tick();
    cap_en = 1'b0;
    rd_ready = 1'b0;
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovfcnt", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("pp_seq", 32'(rd_data[13:6]), 32'(11 + i));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("pp_empty", 32'(count), 32'd0);

    // clear with a concurrent capture
    cap_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_clr_count", 32'(count), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cap_en = 1'b0;
    expseq = 8'd0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(rd_valid), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_ovfcnt", 32'(ovf_cnt), 32'd0);
    single("post_clr", 5'b11010, 1'b0);

    // asynchronous reset between clock edges
    cap_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cap_en = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data", 32'(rd_data), 32'd0);
    #1;
    reset_n = 1'b1;
    expseq = 8'd0;
    tick();
    single("post_rst", 5'b11010, 1'b0);

    // 260 streaming captures with a continuous reader
    do_clear();
    pops = 0;
    rd_ready = 1'b1;
    cap_en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      if (rd_valid) begin
        chk("wrap_seq", 32'(rd_data[13:6]), 32'(pops[7:0]));
        pops++;
      end
      tick();
    end
    cap_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid) begin
        chk("wrap_seq", 32'(rd_data[13:6]), 32'(pops[7:0]));
        pops++;
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("wrap_pops", pops, 32'd260);
    chk("wrap_ovfcnt", 32'(ovf_cnt), 32'd0);
    chk("wrap_count", 32'(count), 32'd0);

    // overflow counter saturation
    do_clear();
    cap_en = 1'b1;
    for (int i = 0; i < 268; i++) tick();
    cap_en = 1'b0;
    chk("sat_ovfcnt", 32'(ovf_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd8);
    chk("sat_ovf", 32'(ovf), 32'd1);
    do_clear();
    chk("sat_clr", 32'(ovf_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
